// File: rtl/wb_tim_cmp_pkg.sv
// Shared constants for the Wishbone timer-compare block: register map, CTRL bit positions,
// compare reset value and a byte-lane merge helper.
package wb_tim_cmp_pkg;

  localparam logic [2:0] ADR_CMP_LO    = 3'd0;
  localparam logic [2:0] ADR_CMP_HI    = 3'd1;
  localparam logic [2:0] ADR_CTRL      = 3'd2;
  localparam logic [2:0] ADR_STATUS    = 3'd3;
  localparam logic [2:0] ADR_PERIOD_LO = 3'd4;
  localparam logic [2:0] ADR_PERIOD_HI = 3'd5;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_PERIODIC = 2;

  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_tim_cmp_if.sv
// Wishbone classic slave bus bundle for wb_tim_cmp.
// Handshake: an access is presented while cyc_i & stb_i are high and is accepted on the edge
// that raises ack_o; ack_o is held for exactly one cycle, so the master drops or changes the
// request in the cycle ack_o is seen (ack_o acts as ready, cyc_i & stb_i as valid).
interface wb_tim_cmp_if #(
  parameter int AW = 3
) ();
  logic          cyc_i;
  logic          stb_i;
  logic [AW-1:0] adr_i;
  logic          we_i;
  logic [31:0]   dat_i;
  logic [3:0]    sel_i;
  logic          ack_o;
  logic [31:0]   dat_o;

  modport master (output cyc_i, stb_i, adr_i, we_i, dat_i, sel_i, input ack_o, dat_o);
  modport slave  (input cyc_i, stb_i, adr_i, we_i, dat_i, sel_i, output ack_o, dat_o);
endinterface

// File: rtl/wb_tim_cmp_core.sv
// Compare engine: cmp/period registers, 64-bit compare, reload adder, pending and irq.
// Periodic reload exists only when TIM_CMP_PERIODIC_EN is defined.
module tim_cmp_core
  import wb_tim_cmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] timebase,
  input  logic        cmp_wr,
  input  logic [63:0] cmp_wdata,
  input  logic        ctrl_wr,
  input  logic [2:0]  ctrl_wdata,
  input  logic        clr,
  input  logic        period_lo_wr,
  input  logic        period_hi_wr,
  input  logic [31:0] period_wdata,
  output logic [63:0] cmp,
  output logic [63:0] period,
  output logic [2:0]  ctrl,
  output logic        pending,
  output logic        irq
);

  logic        en, ie, periodic;
  logic        match, reload;
  logic        en_d, ie_d, pending_d;
  logic [63:0] cmp_d, cmp_reload;

  assign match = en & (timebase >= cmp);

`ifdef TIM_CMP_PERIODIC_EN
  assign reload     = match & periodic & (period != 64'd0);
  assign cmp_reload = cmp + period;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      periodic <= 1'b0;
      period   <= '0;
    end else begin
      if (ctrl_wr)      periodic       <= ctrl_wdata[CTRL_PERIODIC];
      if (period_lo_wr) period[31:0]   <= period_wdata;
      if (period_hi_wr) period[63:32]  <= period_wdata;
    end
  end
`else
  logic unused_ok;
  assign unused_ok  = ^{period_lo_wr, period_hi_wr, period_wdata, ctrl_wdata[CTRL_PERIODIC]};
  assign periodic   = 1'b0;
  assign period     = '0;
  assign reload     = 1'b0;
  assign cmp_reload = cmp;
`endif

  // Hardware set beats W1C; a software commit beats a reload; a CTRL write beats the one-shot clear.
  always_comb begin
    en_d      = en;
    ie_d      = ie;
    pending_d = pending;
    cmp_d     = cmp;
    if (match && !reload) en_d = 1'b0;
    if (ctrl_wr) begin
      en_d = ctrl_wdata[CTRL_EN];
      ie_d = ctrl_wdata[CTRL_IE];
    end
    if (clr)    pending_d = 1'b0;
    if (match)  pending_d = 1'b1;
    if (reload) cmp_d     = cmp_reload;
    if (cmp_wr) cmp_d     = cmp_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      pending <= 1'b0;
      cmp     <= CMP_RESET;
      irq     <= 1'b0;
    end else begin
      en      <= en_d;
      ie      <= ie_d;
      pending <= pending_d;
      cmp     <= cmp_d;
      irq     <= pending_d & ie_d;
    end
  end

  always_comb begin
    ctrl                = '0;
    ctrl[CTRL_EN]       = en;
    ctrl[CTRL_IE]       = ie;
    ctrl[CTRL_PERIODIC] = periodic;
  end

endmodule

// File: rtl/wb_tim_cmp.sv
// Wishbone timer-compare slave: decode, ack, registered read mux and CMP_LO shadow.
// Optional periodic auto-reload is enabled with the TIM_CMP_PERIODIC_EN macro.
module wb_tim_cmp
  import wb_tim_cmp_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_tim_cmp_if.slave   wb,
  input  logic [63:0]   timebase_i,
  output logic          irq_o
);

  logic [AW-1:0] adr;
  logic          access, wr;
  logic          wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status, wr_period_lo, wr_period_hi;
  logic [31:0]   shadow_lo;
  logic [63:0]   cmp, period;
  logic [2:0]    ctrl;
  logic          pending;
  logic [DW-1:0] rdata;

  assign adr    = wb.adr_i;
  assign access = wb.cyc_i & wb.stb_i & ~wb.ack_o;
  assign wr     = access & wb.we_i;

  assign wr_cmp_lo    = wr & (adr == AW'(ADR_CMP_LO));
  assign wr_cmp_hi    = wr & (adr == AW'(ADR_CMP_HI));
  assign wr_ctrl      = wr & (adr == AW'(ADR_CTRL));
  assign wr_status    = wr & (adr == AW'(ADR_STATUS));
  assign wr_period_lo = wr & (adr == AW'(ADR_PERIOD_LO));
  assign wr_period_hi = wr & (adr == AW'(ADR_PERIOD_HI));

  tim_cmp_core u_core (
    .clk          (clk_i),
    .rst_n        (rst_i),
    .timebase     (timebase_i),
    .cmp_wr       (wr_cmp_hi),
    .cmp_wdata    ({merge_bytes(cmp[63:32], wb.dat_i, wb.sel_i), shadow_lo}),
    .ctrl_wr      (wr_ctrl & wb.sel_i[0]),
    .ctrl_wdata   (wb.dat_i[2:0]),
    .clr          (wr_status & wb.sel_i[0] & wb.dat_i[0]),
    .period_lo_wr (wr_period_lo),
    .period_hi_wr (wr_period_hi),
    .period_wdata (wr_period_hi ? merge_bytes(period[63:32], wb.dat_i, wb.sel_i)
                                : merge_bytes(period[31:0],  wb.dat_i, wb.sel_i)),
    .cmp          (cmp),
    .period       (period),
    .ctrl         (ctrl),
    .pending      (pending),
    .irq          (irq_o)
  );

  // CMP_LO reads the live compare value, not the shadow.
  always_comb begin
    rdata = '0;
    case (adr)
      AW'(ADR_CMP_LO):    rdata = DW'(cmp[31:0]);
      AW'(ADR_CMP_HI):    rdata = DW'(cmp[63:32]);
      AW'(ADR_CTRL):      rdata = DW'(ctrl);
      AW'(ADR_STATUS):    rdata = DW'(pending);
      AW'(ADR_PERIOD_LO): rdata = DW'(period[31:0]);
      AW'(ADR_PERIOD_HI): rdata = DW'(period[63:32]);
      default:            rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb.ack_o  <= 1'b0;
      wb.dat_o  <= '0;
      shadow_lo <= '0;
    end else begin
      wb.ack_o <= wb.cyc_i & wb.stb_i & ~wb.ack_o;
      if (access)    wb.dat_o  <= rdata[31:0];
      if (wr_cmp_lo) shadow_lo <= merge_bytes(shadow_lo, wb.dat_i, wb.sel_i);
    end
  end

endmodule

// File: tb/tb_wb_tim_cmp.sv
// Directed and randomized bench for wb_tim_cmp; expectations adapt to TIM_CMP_PERIODIC_EN.
module tb_wb_tim_cmp;
  import wb_tim_cmp_pkg::*;

`ifdef TIM_CMP_PERIODIC_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] timebase;
  logic        irq;
  logic [31:0] rd;
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  wb_tim_cmp_if #(.AW(3)) wb ();

  wb_tim_cmp #(.AW(3), .DW(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb         (wb),
    .timebase_i (timebase),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic set_tb, input logic [63:0] tb_val,
                         output logic [31:0] rdata);
    int n;
    @(negedge clk);
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.adr_i = adr;
    wb.we_i  = we;
    wb.dat_i = dat;
    wb.sel_i = sel;
    if (set_tb) timebase = tb_val;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb.ack_o !== 1'b1 && n < 8);
    check("ack", wb.ack_o, 1'b1);
    rdata    = wb.dat_o;
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(adr, 1'b1, dat, 4'hF, 1'b0, 64'd0, dummy);
  endtask

  task automatic rd_reg(input logic [2:0] adr, output logic [31:0] data);
    wb_xfer(adr, 1'b0, 32'd0, 4'hF, 1'b0, 64'd0, data);
  endtask

  task automatic ramp_to(input logic [63:0] last);
    while (timebase < last) begin
      timebase = timebase + 64'd1;
      @(negedge clk);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] adr, input logic [31:0] exp);
    logic [31:0] data;
    rd_reg(adr, data);
    check(tag, data, exp);
  endtask

  initial begin
    logic        early;
    int          n;
    logic [63:0] c, t, p, cmpe;
    logic        mode, per_eff, pend, en_e;

    rst = 1'b0;
    timebase = 64'd0;
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    wb.adr_i = '0;   wb.dat_i = '0;   wb.sel_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", wb.ack_o, 1'b0);
    check("reset_dat", wb.dat_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_irq", irq, 1'b0);
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), rd);
      check($sformatf("reset_reg%0d", a), rd, (a < 2) ? 32'hFFFF_FFFF : 32'd0);
    end

    // One-shot match
    wr(ADR_CMP_LO, 32'h100);
    wr(ADR_CMP_HI, 32'h0);
    timebase = 64'hF0;
    wr(ADR_CTRL, 32'h3);
    early = 1'b0;
    while (timebase < 64'hFF) begin
      timebase = timebase + 64'd1;
      @(negedge clk);
      if (irq !== 1'b0) early = 1'b1;
    end
    check("oneshot_early", early, 1'b0);
    timebase = 64'h100;
    n = 0;
    while (irq !== 1'b1 && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("oneshot_irq", irq, 1'b1);
    check_reg("oneshot_status", ADR_STATUS, 32'h1);
    check_reg("oneshot_ctrl", ADR_CTRL, 32'h2);
    check_reg("oneshot_cmp", ADR_CMP_LO, 32'h100);
    wr(ADR_STATUS, 32'h1);
    check("oneshot_w1c_irq", irq, 1'b0);
    check_reg("oneshot_w1c_status", ADR_STATUS, 32'h0);

    // Atomic commit
    wr(ADR_CMP_LO, 32'h0);
    wr(ADR_CMP_HI, 32'h1);
    timebase = 64'h50;
    wr(ADR_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    check("atomic_idle_irq", irq, 1'b0);
    wr(ADR_CMP_LO, 32'h10);
    repeat (3) @(negedge clk);
    check("atomic_between_irq", irq, 1'b0);
    check_reg("atomic_live_lo", ADR_CMP_LO, 32'h0);
    wr(ADR_CMP_HI, 32'h0);
    check("atomic_commit_edge_irq", irq, 1'b0);
    @(negedge clk);
    check("atomic_after_commit_irq", irq, 1'b1);
    check_reg("atomic_cmp_lo", ADR_CMP_LO, 32'h10);
    check_reg("atomic_cmp_hi", ADR_CMP_HI, 32'h0);
    wr(ADR_STATUS, 32'h1);
    check("atomic_clear_irq", irq, 1'b0);

    // Byte lanes
    wb_xfer(ADR_CTRL, 1'b1, 32'h7, 4'b0000, 1'b0, 64'd0, rd);
    check_reg("lane_ctrl_sel0", ADR_CTRL, 32'h2);
    wb_xfer(ADR_PERIOD_LO, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 64'd0, rd);
    check_reg("lane_period_lo", ADR_PERIOD_LO, PER ? 32'h00BB_00DD : 32'h0);
    check_reg("unmapped_6", 3'd6, 32'h0);

    // W1C colliding with a hardware match: the set wins
    wr(ADR_CTRL, 32'h0);
    timebase = 64'h1000;
    wr(ADR_CMP_LO, 32'h2000);
    wr(ADR_CMP_HI, 32'h0);
    wr(ADR_STATUS, 32'h1);
    wr(ADR_CTRL, 32'h3);
    check("collide_pre_irq", irq, 1'b0);
    wb_xfer(ADR_STATUS, 1'b1, 32'h1, 4'hF, 1'b1, 64'h2000, rd);
    check_reg("collide_status", ADR_STATUS, 32'h1);
    check("collide_irq", irq, 1'b1);
    wr(ADR_CTRL, 32'h2);
    check_reg("en_clear_keeps_pending", ADR_STATUS, 32'h1);
    wr(ADR_STATUS, 32'h1);
    check("collide_clear_irq", irq, 1'b0);

    // Periodic reload
    wr(ADR_CTRL, 32'h0);
    timebase = 64'hF0;
    wr(ADR_CMP_LO, 32'h100);
    wr(ADR_CMP_HI, 32'h0);
    wr(ADR_PERIOD_LO, 32'h40);
    wr(ADR_PERIOD_HI, 32'h0);
    wr(ADR_STATUS, 32'h1);
    wr(ADR_CTRL, 32'h7);
    ramp_to(64'h120);
    check_reg("periodic_cmp1", ADR_CMP_LO, PER ? 32'h140 : 32'h100);
    ramp_to(64'h160);
    check_reg("periodic_cmp2", ADR_CMP_LO, PER ? 32'h180 : 32'h100);
    ramp_to(64'h1A0);
    check_reg("periodic_cmp3", ADR_CMP_LO, PER ? 32'h1C0 : 32'h100);
    check_reg("periodic_status", ADR_STATUS, 32'h1);
    check_reg("periodic_ctrl", ADR_CTRL, PER ? 32'h7 : 32'h2);

    // Reload wraps modulo 2^64
    wr(ADR_CTRL, 32'h0);
    wr(ADR_STATUS, 32'h1);
    timebase = 64'd0;
    wr(ADR_CMP_LO, 32'hFFFF_FFF0);
    wr(ADR_CMP_HI, 32'hFFFF_FFFF);
    wr(ADR_PERIOD_LO, 32'h20);
    wr(ADR_PERIOD_HI, 32'h0);
    wr(ADR_CTRL, 32'h7);
    timebase = 64'hFFFF_FFFF_FFFF_FFF5;
    @(negedge clk);
    timebase = 64'd5;
    @(negedge clk);
    check_reg("wrap_cmp_lo", ADR_CMP_LO, PER ? 32'h10 : 32'hFFFF_FFF0);
    check_reg("wrap_cmp_hi", ADR_CMP_HI, PER ? 32'h0 : 32'hFFFF_FFFF);
    check_reg("wrap_status", ADR_STATUS, 32'h1);

    // Randomized compares against a closed-form reference
    for (int i = 0; i < 16; i++) begin
      mode = 1'($urandom_range(0, 1));
      c    = ({32'd0, $urandom} << 32 | {32'd0, $urandom}) & 64'h7FFF_FFFF_FFFF_FFFF;
      c    = c | 64'h1000;
      p    = 64'($urandom_range(8, 64));
      t    = c - 64'h100 + 64'($urandom_range(0, 32'h300));
      per_eff = mode & PER;
      if (t >= c) begin
        pend = 1'b1;
        cmpe = per_eff ? c + p * ((t - c) / p + 64'd1) : c;
        en_e = per_eff;
      end else begin
        pend = 1'b0;
        cmpe = c;
        en_e = 1'b1;
      end
      exp_q.push_back(cmpe[31:0]);
      exp_q.push_back(cmpe[63:32]);
      exp_q.push_back({29'd0, per_eff, 1'b1, en_e});
      exp_q.push_back({31'd0, pend});

      wr(ADR_CTRL, 32'h0);
      timebase = 64'd0;
      wr(ADR_STATUS, 32'h1);
      wr(ADR_CMP_LO, c[31:0]);
      wr(ADR_CMP_HI, c[63:32]);
      wr(ADR_PERIOD_LO, p[31:0]);
      wr(ADR_PERIOD_HI, 32'h0);
      wr(ADR_CTRL, mode ? 32'h7 : 32'h3);
      timebase = t;
      repeat (80) @(negedge clk);
      rd_reg(ADR_CMP_LO, rd); check($sformatf("rand%0d_cmp_lo", i), rd, exp_q.pop_front());
      rd_reg(ADR_CMP_HI, rd); check($sformatf("rand%0d_cmp_hi", i), rd, exp_q.pop_front());
      rd_reg(ADR_CTRL, rd);   check($sformatf("rand%0d_ctrl", i), rd, exp_q.pop_front());
      rd_reg(ADR_STATUS, rd); check($sformatf("rand%0d_status", i), rd, exp_q.pop_front());
      check($sformatf("rand%0d_irq", i), irq, pend);
    end

    // Reset while an interrupt is pending
    rst = 1'b0;
    @(negedge clk);
    check("rereset_irq", irq, 1'b0);
    check("rereset_ack", wb.ack_o, 1'b0);
    rst = 1'b1;
    check_reg("rereset_status", ADR_STATUS, 32'h0);
    check_reg("rereset_cmp_lo", ADR_CMP_LO, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_tim_cmp.md
Name: wb_tim_cmp

Overview:
- Wishbone slave that consumes the free-running 64-bit timebase produced by the system timer.
- Holds a 64-bit compare value; raises a level interrupt when timebase >= compare.
- Optionally auto-reloads compare by a programmable period.
- Sits directly downstream of the timer counter, on the same peripheral bus segment. Its interrupt output feeds the CPU interrupt encoder.

Parameters:
- AW, 3, word-address width (registers 0..5 used).
- DW, 32, Wishbone data width; fixed at 32.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-low (asserted when 0).
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- adr_i  in  AW  word address.
- we_i  in  1  write enable.
- dat_i  in  32  write data.
- sel_i  in  4  byte selects; a byte lane is written only if its sel bit is 1.
- ack_o  out  1  Wishbone acknowledge.
- dat_o  out  32  read data, registered.
- timebase_i  in  64  free-running counter value from the timer, same clock domain.
- irq_o  out  1  level interrupt, equals pending AND ie.

Behaviour:
- Register map (word address):
  - 0 CMP_LO: write goes to shadow_lo; read returns live cmp[31:0].
  - 1 CMP_HI: write commits {dat, shadow_lo} to cmp atomically; read returns cmp[63:32].
  - 2 CTRL: bit0 en, bit1 ie, bit2 periodic; other bits read 0.
  - 3 STATUS: bit0 pending, write-1-to-clear.
  - 4 PERIOD_LO and 5 PERIOD_HI: plain R/W.
  - 6, 7: read 0, writes ignored.
- Handshake:
  - ack_o <= stb_i & cyc_i & !ack_o, so each access acks exactly one cycle after strobe and back-to-back strobes ack every other cycle.
  - Writes take effect on the acking edge. dat_o is loaded on the same edge.
- Reset (rst_i=0 at clock edge):
  - ack_o=0, dat_o=0, irq_o=0.
  - cmp=64'hFFFF_FFFF_FFFF_FFFF, shadow_lo=0, CTRL=0, pending=0, period=0.
  - Reset mid-access drops the ack; the master must retry.
- Match:
  - match = en & (timebase_i >= cmp), unsigned 64-bit, evaluated every cycle. The registered compare adds 1 cycle latency.
  - On match, pending <= 1.
  - If periodic and period != 0, also cmp <= cmp + period (wraps modulo 2^64).
  - If not periodic, cmp is unchanged and en is cleared (one-shot).
  - periodic with period=0 behaves as one-shot.
- Simultaneous events:
  - Hardware set of pending and W1C in the same cycle: set wins.
  - CMP_HI commit and periodic reload in the same cycle: software commit wins.
  - Clearing en leaves pending unchanged.
- irq_o is registered: irq_o <= next pending & ie.

Optional Feature:
- Macro: TIM_CMP_PERIODIC_EN.
- Defined: periodic bit and the PERIOD registers are implemented as described above.
- Undefined: CTRL bit2, PERIOD_LO and PERIOD_HI read 0 and writes are ignored; every match is one-shot and clears en. No reload adder is synthesised.

Decomposition:
- Shared package holds the register address constants (CMP_LO..PERIOD_HI), the CTRL bit indices (EN, IE, PERIODIC), and the reset value of cmp.
- One natural sub-module: tim_cmp_core. It contains cmp, the period register, the compare, the reload adder, and the pending bit.
- The top level keeps the Wishbone decode, ack, read mux and shadow_lo.

Test Plan:
- Reset then read all registers: 0 reads 0xFFFFFFFF, 1 reads 0xFFFFFFFF, all others read 0; irq_o=0.
- One-shot match:
  - Stimulus: CMP_LO=0x100, CMP_HI=0, CTRL=0x3, timebase ramps from 0xF0.
  - Response: pending set and irq_o=1 within 2 cycles of timebase reaching 0x100; CTRL reads 0x2.
  - Then write STATUS=1: irq_o drops next cycle.
- Atomic commit:
  - Stimulus: cmp=0x1_0000_0000, timebase=0x50, write CMP_LO=0x10, then CMP_HI=0.
  - Response: no match fires between the two writes; match fires immediately after the CMP_HI commit.
- Periodic (macro defined):
  - Stimulus: cmp=0x100, period=0x40, CTRL=0x7.
  - Response: matches at 0x100, 0x140, 0x180. cmp reads 0x1C0 after the third match.
- Collision and wrap:
  - Stimulus: W1C on STATUS in the same cycle as a match.
  - Response: pending remains 1.
  - Stimulus: periodic with cmp=0xFFFF_FFFF_FFFF_FFF0, period=0x20.
  - Response: cmp wraps to 0x10.
- Byte lanes: write CTRL with sel=0b0000 -> no change; write PERIOD_LO=0xAABBCCDD with sel=0b0101 -> only bytes 0 and 2 are updated.
